// File: rtl/bool_func_eval.sv
// rtl/bool_func_eval.sv - loadable truth-table boolean evaluator with optional minterm sweep
// The sweep engine is built only when BOOL_FUNC_EVAL_SWEEP_EN is defined.
module bool_func_eval #(
  parameter int unsigned          N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0] INIT_TT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tt_wr,
  input  logic [(1<<N_IN)-1:0]   tt_data,
  input  logic                   eval_valid,
  input  logic [N_IN-1:0]        eval_in,
  output logic                   eval_out,
  output logic                   out_valid,
  input  logic                   sweep_start,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [N_IN:0]          ones_count,
  output logic                   const0,
  output logic                   const1
);

  localparam int unsigned TT_W = 1 << N_IN;

  logic [TT_W-1:0] tt_q, tt_d;
  logic            eval_out_q, eval_out_d;
  logic            out_valid_q, out_valid_d;
  logic            tt_wr_ok;

  // Eval always indexes the pre-edge table, so a same-cycle write returns old data.
  always_comb begin
    tt_d        = tt_q;
    eval_out_d  = eval_out_q;
    out_valid_d = eval_valid;
    if (tt_wr && tt_wr_ok) begin
      tt_d = tt_data;
    end
    if (eval_valid) begin
      eval_out_d = tt_q[eval_in];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q        <= INIT_TT;
      eval_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      tt_q        <= tt_d;
      eval_out_q  <= eval_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign eval_out  = eval_out_q;
  assign out_valid = out_valid_q;

`ifdef BOOL_FUNC_EVAL_SWEEP_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TT_W - 1);
  localparam logic [N_IN:0] FULL_CNT = (N_IN+1)'(TT_W);

  state_e        state_q, state_d;
  logic [N_IN:0] idx_q, idx_d;
  logic [N_IN:0] acc_q, acc_d;
  logic [N_IN:0] acc_inc;
  logic [N_IN:0] ones_q, ones_d;
  logic          const0_q, const0_d;
  logic          const1_q, const1_d;

  assign acc_inc = acc_q + {{N_IN{1'b0}}, tt_q[idx_q[N_IN-1:0]]};

  // Results are captured on the last RUN edge so they are visible alongside sweep_done.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ones_d   = ones_q;
    const0_d = const0_q;
    const1_d = const1_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_inc;
        idx_d = idx_q + (N_IN+1)'(1);
        if (idx_q == LAST_IDX) begin
          ones_d   = acc_inc;
          const0_d = (acc_inc == '0);
          const1_d = (acc_inc == FULL_CNT);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      ones_q   <= '0;
      const0_q <= 1'b0;
      const1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ones_q   <= ones_d;
      const0_q <= const0_d;
      const1_q <= const1_d;
    end
  end

  assign tt_wr_ok   = (state_q != S_RUN);
  assign sweep_busy = (state_q == S_RUN);
  assign sweep_done = (state_q == S_DONE);
  assign ones_count = ones_q;
  assign const0     = const0_q;
  assign const1     = const1_q;

`else

  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign tt_wr_ok           = 1'b1;
  assign sweep_busy         = 1'b0;
  assign sweep_done         = 1'b0;
  assign ones_count         = '0;
  assign const0             = 1'b0;
  assign const1             = 1'b0;

`endif

endmodule
